// File: rtl/muldiv_hilo_controller_pkg.sv
// Shared encodings for the multiply/divide HI/LO controller: command opcodes,
// FSM states and opcode classification helpers.
package muldiv_hilo_controller_pkg;

    typedef enum logic [2:0] {
        MD_OP_MULT  = 3'd0,
        MD_OP_MULTU = 3'd1,
        MD_OP_DIV   = 3'd2,
        MD_OP_DIVU  = 3'd3,
        MD_OP_MTHI  = 3'd4,
        MD_OP_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } md_state_e;

    // Opcodes 6 and 7 fall through every helper and so have no effect.
    function automatic logic op_is_mul(input logic [2:0] op);
        return (op == MD_OP_MULT) || (op == MD_OP_MULTU);
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == MD_OP_MULT) || (op == MD_OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_divider_core.sv
// Unsigned restoring divider: DATA_BITS iterations after start, then ready for
// exactly one cycle while quotient/remainder are valid.
module muldiv_divider_core #(
    parameter int DATA_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] dividend,
    input  logic [DATA_BITS-1:0] divisor,
    output logic [DATA_BITS-1:0] quotient,
    output logic [DATA_BITS-1:0] remainder,
    output logic                 ready
);
    localparam int CW = $clog2(DATA_BITS + 1);

    logic [CW-1:0]        r_cnt;
    logic                 r_act;
    logic [DATA_BITS-1:0] r_quo;
    logic [DATA_BITS-1:0] r_rem;
    logic [DATA_BITS-1:0] r_dvs;
    logic [DATA_BITS:0]   w_shift;
    logic [DATA_BITS:0]   w_diff;

    assign w_shift = {r_rem, r_quo[DATA_BITS-1]};
    assign w_diff  = w_shift - {1'b0, r_dvs};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_act <= 1'b0;
            r_cnt <= '0;
            r_quo <= '0;
            r_rem <= '0;
            r_dvs <= '0;
        end else if (start) begin
            r_act <= 1'b1;
            r_cnt <= CW'(DATA_BITS);
            r_quo <= dividend;
            r_rem <= '0;
            r_dvs <= divisor;
        end else if (r_act) begin
            if (r_cnt == '0) begin
                r_act <= 1'b0;
            end else begin
                r_cnt <= r_cnt - CW'(1);
                // A borrow out of the trial subtract means restore (keep the shifted value).
                if (!w_diff[DATA_BITS]) begin
                    r_rem <= w_diff[DATA_BITS-1:0];
                    r_quo <= {r_quo[DATA_BITS-2:0], 1'b1};
                end else begin
                    r_rem <= w_shift[DATA_BITS-1:0];
                    r_quo <= {r_quo[DATA_BITS-2:0], 1'b0};
                end
            end
        end
    end

    assign quotient  = r_quo;
    assign remainder = r_rem;
    assign ready     = r_act && (r_cnt == '0);

endmodule

// File: rtl/muldiv_hilo_controller.sv
// Sequences MULT/MULTU/DIV/DIVU/MTHI/MTLO commands and commits results to HI/LO.
// state   | meaning
// ST_IDLE | accepting commands, MTHI/MTLO write directly
// ST_MUL  | product registered, counting down to the commit edge
// ST_DIV  | divider core iterating; commit with sign fix when it is ready
module muldiv_hilo_controller
    import muldiv_hilo_controller_pkg::*;
#(
    parameter int DATA_BITS  = 32,
    parameter int MUL_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic [DATA_BITS-1:0] a,
    input  logic [DATA_BITS-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [DATA_BITS-1:0] hi,
    output logic [DATA_BITS-1:0] lo
);
    localparam int CW  = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam int MSB = DATA_BITS - 1;

    md_state_e              r_state, w_state_nxt;
    logic [CW-1:0]          r_mul_cnt;
    logic [2*DATA_BITS-1:0] r_prod;
    logic [DATA_BITS-1:0]   r_a, r_hi, r_lo;
    logic                   r_b_zero, r_neg_q, r_neg_r, r_done;
    logic                   w_load_mul, w_load_div, w_commit_mul, w_commit_div;
    logic                   w_wr_hi, w_wr_lo, w_signed, w_core_ready;
    logic [2*DATA_BITS-1:0] w_a_ext, w_b_ext, w_prod;
    logic [DATA_BITS-1:0]   w_a_mag, w_b_mag, w_core_q, w_core_r, w_quo, w_rem;

    assign w_signed = op_is_signed(op);
    assign w_a_ext  = {{DATA_BITS{w_signed & a[MSB]}}, a};
    assign w_b_ext  = {{DATA_BITS{w_signed & b[MSB]}}, b};
    assign w_prod   = w_a_ext * w_b_ext;
    assign w_a_mag  = (w_signed && a[MSB]) ? -a : a;
    assign w_b_mag  = (w_signed && b[MSB]) ? -b : b;

    muldiv_divider_core #(.DATA_BITS(DATA_BITS)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (w_load_div),
        .dividend  (w_a_mag),
        .divisor   (w_b_mag),
        .quotient  (w_core_q),
        .remainder (w_core_r),
        .ready     (w_core_ready)
    );

    // Zero divisor overrides the core; the most-negative / -1 case falls out naturally.
    assign w_quo = r_b_zero ? '1  : (r_neg_q ? -w_core_q : w_core_q);
    assign w_rem = r_b_zero ? r_a : (r_neg_r ? -w_core_r : w_core_r);

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_load_mul   = 1'b0;
        w_load_div   = 1'b0;
        w_commit_mul = 1'b0;
        w_commit_div = 1'b0;
        w_wr_hi      = 1'b0;
        w_wr_lo      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (op_is_mul(op)) begin
                        w_load_mul  = 1'b1;
                        w_state_nxt = ST_MUL;
                    end else if (op_is_div(op)) begin
                        w_load_div  = 1'b1;
                        w_state_nxt = ST_DIV;
                    end else begin
                        w_wr_hi = (op == MD_OP_MTHI);
                        w_wr_lo = (op == MD_OP_MTLO);
                    end
                end
            end
            ST_MUL: begin
                if (r_mul_cnt == '0) begin
                    w_commit_mul = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end
            end
            ST_DIV: begin
                if (w_core_ready) begin
                    w_commit_div = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
            r_mul_cnt <= '0;
            r_prod    <= '0;
            r_a       <= '0;
            r_b_zero  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
        end else begin
            r_done <= w_commit_mul | w_commit_div;
            if (w_load_mul) begin
                r_prod    <= w_prod;
                r_mul_cnt <= CW'(MUL_CYCLES - 1);
            end else if ((r_state == ST_MUL) && (r_mul_cnt != '0)) begin
                r_mul_cnt <= r_mul_cnt - CW'(1);
            end
            if (w_load_div) begin
                r_a      <= a;
                r_b_zero <= (b == '0);
                r_neg_q  <= w_signed & (a[MSB] ^ b[MSB]);
                r_neg_r  <= w_signed & a[MSB];
            end
            if (w_wr_hi) r_hi <= a;
            if (w_wr_lo) r_lo <= a;
            if (w_commit_mul) {r_hi, r_lo} <= r_prod;
            if (w_commit_div) begin
                r_hi <= w_rem;
                r_lo <= w_quo;
            end
        end
    end

    assign busy = (r_state != ST_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_hilo_controller.sv
// Randomized and directed bench for muldiv_hilo_controller against an
// arithmetic reference model of HI/LO and the command latencies.
module tb_muldiv_hilo_controller;
    localparam int N  = 32;
    localparam int MC = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [N-1:0] a, b;
    logic         busy, done;
    logic [N-1:0] hi, lo;

    int           n_checks = 0;
    int           n_pass   = 0;
    logic [N-1:0] m_hi = '0;
    logic [N-1:0] m_lo = '0;

    muldiv_hilo_controller #(.DATA_BITS(N), .MUL_CYCLES(MC)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Returns {hi, lo} the architecture defines for a multiply/divide command.
    function automatic logic [63:0] ref_result(input logic [2:0] c_op, input logic [31:0] c_a,
                                               input logic [31:0] c_b);
        int     sa, sb;
        longint sp;
        case (c_op)
            3'd0: begin
                sp = longint'(int'(c_a)) * longint'(int'(c_b));
                return sp;
            end
            3'd1: return {32'd0, c_a} * {32'd0, c_b};
            3'd2: begin
                if (c_b == 32'd0) return {c_a, 32'hFFFF_FFFF};
                if (c_a == 32'h8000_0000 && c_b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                sa = int'(c_a);
                sb = int'(c_b);
                return {32'(sa % sb), 32'(sa / sb)};
            end
            3'd3: begin
                if (c_b == 32'd0) return {c_a, 32'hFFFF_FFFF};
                return {c_a % c_b, c_a / c_b};
            end
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // Issues one command and follows it to completion; b2b issues it in the
    // current (done) cycle, disturb pokes ignored MTHI/MULT starts mid-divide.
    task automatic do_cmd(input logic [2:0] c_op, input logic [31:0] c_a, input logic [31:0] c_b,
                          input bit b2b, input bit disturb);
        logic [63:0] exp_hl;
        int          lat;
        bit          stable;
        if (!b2b) begin
            @(negedge clk);
            chk("done_single_cycle", 64'(done), 64'd0);
        end
        start = 1'b1;
        op    = c_op;
        a     = c_a;
        b     = c_b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        if (c_op <= 3'd3) begin
            lat    = (c_op <= 3'd1) ? MC : N + 1;
            exp_hl = ref_result(c_op, c_a, c_b);
            stable = 1'b1;
            for (int k = 0; k < lat; k++) begin
                if (busy !== 1'b1 || done !== 1'b0 || hi !== m_hi || lo !== m_lo) stable = 1'b0;
                if (disturb && k == 5) begin
                    start = 1'b1; op = 3'd4; a = 32'hAAAA_0000;
                end else if (disturb && k == 6) begin
                    start = 1'b1; op = 3'd0; a = 32'd7; b = 32'd9;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
            end
            start = 1'b0;
            chk($sformatf("inflight_op%0d", c_op), 64'(stable), 64'd1);
            m_hi = exp_hl[63:32];
            m_lo = exp_hl[31:0];
            chk($sformatf("result_op%0d", c_op), {hi, lo}, {m_hi, m_lo});
            chk("commit_busy_done", {62'd0, busy, done}, 64'd1);
        end else begin
            if (c_op == 3'd4) m_hi = c_a;
            else if (c_op == 3'd5) m_lo = c_a;
            chk($sformatf("idle_hilo_op%0d", c_op), {hi, lo}, {m_hi, m_lo});
            chk("idle_busy_done", {62'd0, busy, done}, 64'd0);
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        bit          saw_done;

        // Reset held together with an MTHI start: reset must win.
        rst = 1'b1; start = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF; b = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_hilo", {hi, lo}, 64'd0);
        chk("reset_busy_done", {62'd0, busy, done}, 64'd0);
        start = 1'b0;
        rst   = 1'b0;

        do_cmd(3'd0, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
        do_cmd(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_cmd(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        do_cmd(3'd3, 32'd7, 32'd2, 1'b1, 1'b0);
        do_cmd(3'd3, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
        do_cmd(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_cmd(3'd2, 32'hFFFF_FF9C, 32'd7, 1'b0, 1'b1);
        do_cmd(3'd5, 32'h0000_0055, 32'd0, 1'b1, 1'b0);
        do_cmd(3'd6, 32'h1111_2222, 32'd3, 1'b0, 1'b0);
        do_cmd(3'd2, 32'd5, 32'd0, 1'b0, 1'b0);

        // Reset ten cycles into a divide: clears HI/LO and never pulses done.
        @(negedge clk);
        start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        m_hi = '0;
        m_lo = '0;
        chk("midop_reset_hilo", {hi, lo}, 64'd0);
        chk("midop_reset_busy_done", {62'd0, busy, done}, 64'd0);
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("midop_reset_no_done", 64'(saw_done), 64'd0);
        do_cmd(3'd1, 32'd3, 32'd4, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = pick_val();
            rb  = pick_val();
            do_cmd(rop, ra, rb, 1'($urandom_range(0, 1)),
                   (rop == 3'd2 || rop == 3'd3) && ($urandom_range(0, 3) == 0));
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
